regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Write-back stage driving the write port of the 32×32 register file. It accepts retiring instructions over a valid/ready handshake and selects the result source: ALU result, load data or jal link address. Load data may return several cycles late from data memory; the block waits for it. It then issues exactly one write pulse, plus forwarding and load-use stall indications back to decode. It runs on the posedge of the core clock, so its outputs are stable when the register file samples them on the following negedge.

## Interface
- DATA_W, 32, datapath and register width
- MEM_TIMEOUT, 15, maximum cycles spent waiting for load data (1..255)
- clock  in  1  core clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_valid  in  1  retiring instruction present
- in_ready  out  1  block can accept this cycle
- in_src  in  2  00 ALU, 01 load, 10 jal link, 11 reserved
- in_RegWrite  in  1  instruction writes a register
- in_rd  in  5  destination register
- in_alu_result  in  DATA_W  ALU result
- in_pc_address  in  DATA_W  PC of the retiring instruction
- mem_valid  in  1  load data valid (single-cycle pulse)
- mem_data  in  DATA_W  load data
- write_data_in  out  DATA_W  register-file write data
- rd  out  5  register-file write address
- WriteEnable  out  1  register-file write strobe
- rs_read, rt_read  in  5 each  decode-stage source registers
- fwd_rs_hit, fwd_rt_hit  out  1 each  write_data_in is to be bypassed to rs/rt
- stall  out  1  load-use hazard; decode must hold
- mem_err  out  1  sticky; a load timed out
- retire_count  out  32  instructions retired

## Operation
- States: IDLE, WAIT_MEM, COMMIT.
- in_ready = 1 in IDLE and COMMIT, 0 in WAIT_MEM. An accept is in_valid & in_ready at a posedge.
- On accept with in_src=01:
  - latch rd and RegWrite;
  - go to WAIT_MEM and clear the wait counter.
- On any other accept:
  - latch data: 00 gives in_alu_result; 10 gives in_pc_address+4 (mod 2^DATA_W) and forces rd=31, RegWrite=1; 11 gives data 0 and RegWrite=0;
  - go to COMMIT.
- WAIT_MEM:
  - mem_valid latches mem_data and goes to COMMIT.
  - Otherwise the counter increments. When it reaches MEM_TIMEOUT, the block goes to COMMIT with RegWrite forced 0 and sets mem_err.
- COMMIT lasts one cycle. WriteEnable = RegWrite & (rd != 0).
  - An accept in COMMIT goes directly to the next state (WAIT_MEM or COMMIT); otherwise go to IDLE.
- mem_valid outside WAIT_MEM is ignored, including in the accept cycle of the load itself.
- retire_count increments on every exit from COMMIT, including suppressed writes. It wraps from 0xFFFFFFFF to 0.
- Forwarding (combinational from state and latched rd):
  - fwd_rs_hit = WriteEnable & (rd == rs_read);
  - fwd_rt_hit = WriteEnable & (rd == rt_read).
- stall = (state == WAIT_MEM) & latched RegWrite & (latched rd != 0) & (latched rd == rs_read | latched rd == rt_read).
- rd = 0 never asserts WriteEnable, fwd_*_hit or stall.

## Timing
- Reset values:
  - state IDLE, in_ready 1;
  - write_data_in 0, rd 0, WriteEnable 0;
  - fwd_rs_hit 0, fwd_rt_hit 0, stall 0;
  - mem_err 0, retire_count 0.
- Reset mid-WAIT_MEM or mid-COMMIT aborts: no write, no count.
- Non-load instruction: accepted at edge N, WriteEnable high for cycle N→N+1. The register file writes on the negedge inside that cycle.
- Throughput for back-to-back non-load instructions: one per cycle. WriteEnable stays high continuously while rd/data change at each edge.
- Load instruction: mem_valid sampled at edge M (M ≥ N+1), WriteEnable high for cycle M→M+1. in_ready stays low from N+1 through M.
- Timeout: COMMIT entered at edge N+MEM_TIMEOUT. mem_err rises at that same edge and stays high until reset.
- write_data_in, rd and WriteEnable are registered (flop outputs, no glitches at the negedge). fwd and stall are combinational from flops and rs_read/rt_read.

## Test plan
- Reset, then ALU retire with rd=5, data 0x1234: WriteEnable=1 for exactly one cycle, rd=5, write_data_in=0x1234, retire_count=1.
- jal with in_pc_address 0x00400020: rd=31, write_data_in=0x00400024. Retire with in_RegWrite=1, rd=0: WriteEnable stays 0, count increments.
- Load to rd=8, mem_valid three cycles later with 0xDEADBEEF:
  - stall=1 while rs_read=8 during WAIT_MEM;
  - in_ready=0 during the wait;
  - write of 0xDEADBEEF one cycle after mem_valid.
- Load with mem_valid never asserted, MEM_TIMEOUT=15: COMMIT at cycle 15 with WriteEnable=0, mem_err=1 sticky, and the next ALU instruction is accepted normally.
- Back-to-back ALU writes to r3, r4, r3 with rs_read=3: WriteEnable high for 3 consecutive cycles, fwd_rs_hit=1,0,1.
- Reset asserted mid-WAIT_MEM, then a late mem_valid: no write, state IDLE, retire_count unchanged. Also preload retire_count to 0xFFFFFFFF, retire one instruction, and check it wraps to 0.

Source files
------------

// File: rtl/regfile_writeback_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_writeback_if
//  Description : Bundle of the retire handshake, load-return, register-file
//                write port, hazard indications and retire-counter preload
//                used by the write-back stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_writeback_if #(
   parameter int DATA_W = 32
);
   // retire handshake
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_src;
   logic              in_RegWrite;
   logic [4:0]        in_rd;
   logic [DATA_W-1:0] in_alu_result;
   logic [DATA_W-1:0] in_pc_address;
   // load data return
   logic              mem_valid;
   logic [DATA_W-1:0] mem_data;
   // register-file write port
   logic [DATA_W-1:0] write_data_in;
   logic [4:0]        rd;
   logic              WriteEnable;
   // decode-side hazard signals
   logic [4:0]        rs_read;
   logic [4:0]        rt_read;
   logic              fwd_rs_hit;
   logic              fwd_rt_hit;
   logic              stall;
   // status and counters
   logic              mem_err;
   logic [31:0]       retire_count;
   // debug preload of the retire counter (one-cycle strobe)
   logic              cnt_load;
   logic [31:0]       cnt_value;

   // write-back stage side
   modport slave (
      input  in_valid, in_src, in_RegWrite, in_rd, in_alu_result, in_pc_address,
      input  mem_valid, mem_data, rs_read, rt_read, cnt_load, cnt_value,
      output in_ready, write_data_in, rd, WriteEnable,
      output fwd_rs_hit, fwd_rt_hit, stall, mem_err, retire_count
   );

   // pipeline / environment side
   modport master (
      output in_valid, in_src, in_RegWrite, in_rd, in_alu_result, in_pc_address,
      output mem_valid, mem_data, rs_read, rt_read, cnt_load, cnt_value,
      input  in_ready, write_data_in, rd, WriteEnable,
      input  fwd_rs_hit, fwd_rt_hit, stall, mem_err, retire_count
   );
endinterface
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_writeback
//  Description : Write-back stage. Accepts retiring instructions, selects the
//                result source (ALU / load / jal link), waits for late load
//                data with a timeout, and drives one registered write pulse
//                into the register file plus forwarding and load-use stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_writeback #(
   parameter int DATA_W      = 32,
   parameter int MEM_TIMEOUT = 15
) (
   input wire clk,
   input wire rst,
   regfile_writeback_if.slave bus
);

   localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);
   localparam logic [1:0] SRC_ALU   = 2'b00;
   localparam logic [1:0] SRC_LOAD  = 2'b01;
   localparam logic [1:0] SRC_JAL   = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_MEM = 2'd1,
      ST_COMMIT   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [4:0]        rd_q, rd_d;
   logic              regwrite_q, regwrite_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              we_q, we_d;
   logic [7:0]        wait_cnt_q, wait_cnt_d;
   logic              mem_err_q, mem_err_d;
   logic [31:0]       retire_q, retire_d;

   logic              ready;
   logic              accept;
   logic [4:0]        new_rd;
   logic              new_rw;
   logic [7:0]        wait_cnt_inc;

   assign ready        = (state_q != ST_WAIT_MEM);
   assign accept       = bus.in_valid & ready;
   assign wait_cnt_inc = wait_cnt_q + 8'd1;

   // Next-state, operand latching and write-strobe generation
   always_comb begin
      state_d    = state_q;
      rd_d       = rd_q;
      regwrite_d = regwrite_q;
      data_d     = data_q;
      we_d       = 1'b0;
      wait_cnt_d = wait_cnt_q;
      mem_err_d  = mem_err_q;
      new_rd     = bus.in_rd;
      new_rw     = bus.in_RegWrite;

      case (state_q)
         ST_IDLE, ST_COMMIT: begin
            if (accept) begin
               if (bus.in_src == SRC_LOAD) begin
                  // mem_valid in this cycle is deliberately not looked at
                  state_d    = ST_WAIT_MEM;
                  rd_d       = bus.in_rd;
                  regwrite_d = bus.in_RegWrite;
                  wait_cnt_d = 8'd0;
               end else begin
                  state_d = ST_COMMIT;
                  case (bus.in_src)
                     SRC_ALU: begin
                        data_d = bus.in_alu_result;
                     end
                     SRC_JAL: begin
                        data_d = bus.in_pc_address + DATA_W'(4);
                        new_rd = 5'd31;
                        new_rw = 1'b1;
                     end
                     default: begin
                        // reserved source: retires without writing
                        data_d = '0;
                        new_rw = 1'b0;
                     end
                  endcase
                  rd_d       = new_rd;
                  regwrite_d = new_rw;
                  we_d       = new_rw & (new_rd != 5'd0);
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_WAIT_MEM: begin
            if (bus.mem_valid) begin
               state_d = ST_COMMIT;
               data_d  = bus.mem_data;
               we_d    = regwrite_q & (rd_q != 5'd0);
            end else if (wait_cnt_inc == TIMEOUT_C) begin
               // give up on the load: retire it without a write
               state_d    = ST_COMMIT;
               regwrite_d = 1'b0;
               mem_err_d  = 1'b1;
               wait_cnt_d = wait_cnt_inc;
            end else begin
               wait_cnt_d = wait_cnt_inc;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Retire counter: debug preload wins over the commit increment
   always_comb begin
      retire_d = retire_q;
      if (bus.cnt_load) begin
         retire_d = bus.cnt_value;
      end else if (state_q == ST_COMMIT) begin
         retire_d = retire_q + 32'd1;
      end
   end

   // State and output registers, cleared immediately by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rd_q       <= 5'd0;
         regwrite_q <= 1'b0;
         data_q     <= '0;
         we_q       <= 1'b0;
         wait_cnt_q <= 8'd0;
         mem_err_q  <= 1'b0;
         retire_q   <= 32'd0;
      end else begin
         state_q    <= state_d;
         rd_q       <= rd_d;
         regwrite_q <= regwrite_d;
         data_q     <= data_d;
         we_q       <= we_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
         retire_q   <= retire_d;
      end
   end

   assign bus.in_ready      = ready;
   assign bus.write_data_in = data_q;
   assign bus.rd            = rd_q;
   assign bus.WriteEnable   = we_q;
   assign bus.mem_err       = mem_err_q;
   assign bus.retire_count  = retire_q;

   // we_q already excludes rd == 0, so forwarding never hits r0
   assign bus.fwd_rs_hit = we_q & (rd_q == bus.rs_read);
   assign bus.fwd_rt_hit = we_q & (rd_q == bus.rt_read);

   assign bus.stall = (state_q == ST_WAIT_MEM) & regwrite_q & (rd_q != 5'd0) &
                      ((rd_q == bus.rs_read) | (rd_q == bus.rt_read));

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_writeback
//  Description : Self-checking bench for regfile_writeback: a cycle model of
//                the retire behaviour plus directed hand-checked scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_writeback;

   localparam int TIMEOUT = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   regfile_writeback_if #(.DATA_W(32)) bus ();

   regfile_writeback #(.DATA_W(32), .MEM_TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_waiting = 0;   // a load is outstanding
   logic [4:0]  m_wrd = 0;
   bit          m_wrw = 0;
   int          m_age = 0;        // cycles spent waiting
   bit          m_retiring = 0;   // an instruction retires in the current cycle
   bit          m_we = 0;
   logic [4:0]  m_rd = 0;
   logic [31:0] m_data = 0;
   logic [31:0] m_count = 0;
   bit          m_err = 0;

   always @(posedge clk or posedge rst) begin
      bit          done;
      bit          wr;
      logic [4:0]  r;
      logic [31:0] d;
      if (rst) begin
         m_waiting = 0; m_age = 0; m_retiring = 0; m_we = 0;
         m_count = 0; m_err = 0;
      end else begin
         if (bus.cnt_load) m_count = bus.cnt_value;
         else if (m_retiring) m_count = m_count + 1;
         done = 0; wr = 0; r = 0; d = 0;
         if (m_waiting) begin
            if (bus.mem_valid) begin
               done = 1; wr = m_wrw; r = m_wrd; d = bus.mem_data;
               m_waiting = 0;
            end else begin
               m_age = m_age + 1;
               if (m_age == TIMEOUT) begin
                  done = 1; wr = 0; r = m_wrd; m_err = 1; m_waiting = 0;
               end
            end
         end else if (bus.in_valid) begin
            if (bus.in_src == 2'b01) begin
               m_waiting = 1; m_age = 0; m_wrd = bus.in_rd; m_wrw = bus.in_RegWrite;
            end else begin
               done = 1;
               r  = (bus.in_src == 2'b10) ? 5'd31 : bus.in_rd;
               wr = (bus.in_src == 2'b10) ? 1'b1 :
                    (bus.in_src == 2'b00) ? bus.in_RegWrite : 1'b0;
               d  = (bus.in_src == 2'b10) ? bus.in_pc_address + 32'd4 :
                    (bus.in_src == 2'b00) ? bus.in_alu_result : 32'd0;
            end
         end
         m_retiring = done;
         m_we   = done && wr && (r != 0);
         m_rd   = r;
         m_data = d;
      end
   end

   // ---------------- per-cycle comparison ----------------
   always @(negedge clk) begin
      if (!rst) begin
         chk("WriteEnable", bus.WriteEnable, m_we);
         chk("in_ready", bus.in_ready, !m_waiting);
         chk("mem_err", bus.mem_err, m_err);
         chk("retire_count", bus.retire_count, m_count);
         chk("fwd_rs_hit", bus.fwd_rs_hit, m_we && m_rd == bus.rs_read);
         chk("fwd_rt_hit", bus.fwd_rt_hit, m_we && m_rd == bus.rt_read);
         chk("stall", bus.stall, m_waiting && m_wrw && m_wrd != 0 &&
             (m_wrd == bus.rs_read || m_wrd == bus.rt_read));
         if (m_we) begin
            chk("rd", bus.rd, m_rd);
            chk("write_data_in", bus.write_data_in, m_data);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic issue(input logic [1:0] src, input logic rw, input logic [4:0] rdx,
                        input logic [31:0] alu, input logic [31:0] pc);
      bit rdy;
      int budget;
      @(posedge clk); #1;
      bus.in_valid = 1; bus.in_src = src; bus.in_RegWrite = rw; bus.in_rd = rdx;
      bus.in_alu_result = alu; bus.in_pc_address = pc;
      budget = 0;
      do begin
         @(negedge clk); rdy = bus.in_ready;
         @(posedge clk); #1;
         budget++;
      end while (!rdy && budget < 40);
      if (!rdy) begin
         checks++; errors++;
         $display("FAIL accept_timeout: in_ready got 0 expected 1");
      end
      bus.in_valid = 0;
   endtask

   task automatic neg();
      @(negedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      bus.in_valid = 0; bus.in_src = 0; bus.in_RegWrite = 0; bus.in_rd = 0;
      bus.in_alu_result = 0; bus.in_pc_address = 0; bus.mem_valid = 0;
      bus.mem_data = 0; bus.rs_read = 0; bus.rt_read = 0;
      bus.cnt_load = 0; bus.cnt_value = 0;
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset in_ready", bus.in_ready, 1);
      chk("reset WriteEnable", bus.WriteEnable, 0);
      chk("reset rd", bus.rd, 0);
      chk("reset write_data_in", bus.write_data_in, 0);
      chk("reset stall", bus.stall, 0);
      chk("reset mem_err", bus.mem_err, 0);
      chk("reset retire_count", bus.retire_count, 0);
      rst = 0;

      // ALU retire
      issue(2'b00, 1, 5'd5, 32'h1234, 32'h0);
      neg();
      chk("alu we", bus.WriteEnable, 1);
      chk("alu rd", bus.rd, 5);
      chk("alu data", bus.write_data_in, 32'h1234);
      neg();
      chk("alu we pulse end", bus.WriteEnable, 0);
      chk("alu count", bus.retire_count, 1);

      // jal, then a write to r0
      issue(2'b10, 0, 5'd7, 32'h0, 32'h0040_0020);
      neg();
      chk("jal we", bus.WriteEnable, 1);
      chk("jal rd", bus.rd, 31);
      chk("jal data", bus.write_data_in, 32'h0040_0024);
      issue(2'b00, 1, 5'd0, 32'hAAAA, 32'h0);
      neg();
      chk("r0 we", bus.WriteEnable, 0);
      neg();
      chk("r0 count", bus.retire_count, 3);

      // load with mem_valid three cycles after accept
      bus.rs_read = 5'd8;
      issue(2'b01, 1, 5'd8, 32'h0, 32'h0);
      neg();
      chk("load ready", bus.in_ready, 0);
      chk("load stall", bus.stall, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.mem_valid = 1; bus.mem_data = 32'hDEAD_BEEF;
      neg();
      chk("load ready2", bus.in_ready, 0);
      chk("load stall2", bus.stall, 1);
      @(posedge clk); #1;
      bus.mem_valid = 0;
      neg();
      chk("load we", bus.WriteEnable, 1);
      chk("load data", bus.write_data_in, 32'hDEAD_BEEF);
      chk("load rd", bus.rd, 8);
      chk("load fwd_rs", bus.fwd_rs_hit, 1);
      chk("load stall off", bus.stall, 0);

      // load timeout
      bus.rs_read = 5'd0;
      issue(2'b01, 1, 5'd9, 32'h0, 32'h0);
      repeat (TIMEOUT) begin
         neg();
         chk("timeout waiting", bus.in_ready, 0);
         chk("timeout err low", bus.mem_err, 0);
      end
      neg();
      chk("timeout ready", bus.in_ready, 1);
      chk("timeout err", bus.mem_err, 1);
      chk("timeout we", bus.WriteEnable, 0);
      issue(2'b00, 1, 5'd2, 32'h55, 32'h0);
      neg();
      chk("post-timeout we", bus.WriteEnable, 1);
      chk("post-timeout data", bus.write_data_in, 32'h55);
      chk("err sticky", bus.mem_err, 1);

      // back-to-back ALU writes r3, r4, r3
      bus.rs_read = 5'd3;
      @(posedge clk); #1;
      bus.in_valid = 1; bus.in_src = 2'b00; bus.in_RegWrite = 1;
      bus.in_rd = 5'd3; bus.in_alu_result = 32'h11;
      @(posedge clk); #1;
      bus.in_rd = 5'd4; bus.in_alu_result = 32'h22;
      neg();
      chk("b2b0 we", bus.WriteEnable, 1);
      chk("b2b0 fwd", bus.fwd_rs_hit, 1);
      @(posedge clk); #1;
      bus.in_rd = 5'd3; bus.in_alu_result = 32'h33;
      neg();
      chk("b2b1 we", bus.WriteEnable, 1);
      chk("b2b1 fwd", bus.fwd_rs_hit, 0);
      chk("b2b1 data", bus.write_data_in, 32'h22);
      @(posedge clk); #1;
      bus.in_valid = 0;
      neg();
      chk("b2b2 we", bus.WriteEnable, 1);
      chk("b2b2 fwd", bus.fwd_rs_hit, 1);
      chk("b2b2 data", bus.write_data_in, 32'h33);
      neg();
      chk("b2b end we", bus.WriteEnable, 0);

      // reserved source retires without writing
      issue(2'b11, 1, 5'd6, 32'h77, 32'h0);
      neg();
      chk("reserved we", bus.WriteEnable, 0);

      // reset in the middle of a load; mem_valid in accept cycle ignored
      bus.rs_read = 5'd10;
      bus.mem_valid = 1; bus.mem_data = 32'hBAD0_0001;
      issue(2'b01, 1, 5'd10, 32'h0, 32'h0);
      bus.mem_valid = 0;
      neg();
      chk("accept-cycle mem_valid ignored", bus.in_ready, 0);
      #2 rst = 1;
      #1;
      chk("abort ready", bus.in_ready, 1);
      chk("abort stall", bus.stall, 0);
      chk("abort count", bus.retire_count, 0);
      @(posedge clk); #1;
      rst = 0;
      bus.mem_valid = 1; bus.mem_data = 32'hBAD0_0002;
      @(posedge clk); #1;
      bus.mem_valid = 0;
      neg();
      chk("late mem_valid we", bus.WriteEnable, 0);
      chk("late mem_valid count", bus.retire_count, 0);

      // counter wrap
      @(posedge clk); #1;
      bus.cnt_load = 1; bus.cnt_value = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      bus.cnt_load = 0;
      neg();
      chk("preload", bus.retire_count, 32'hFFFF_FFFF);
      issue(2'b00, 1, 5'd1, 32'h7, 32'h0);
      neg();
      chk("wrap we", bus.WriteEnable, 1);
      neg();
      chk("wrap count", bus.retire_count, 0);

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
